// File: rtl/mkmif_spi_sram.sv
// SPI mode-0 responder that emulates a 23K640-class serial SRAM (READ/WRITE/RDSR/WRSR), oversampled by clk.
// Defining MKMIF_SPI_SRAM_PAGE_MODE_EN makes status mode 10 a 32-byte page mode; otherwise mode 10 is stored as byte mode.
module mkmif_spi_sram #(
    parameter int ADDR_BITS = 13
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       spi_sclk,
    input  logic       spi_cs_n,
    input  logic       spi_di,
    output logic       spi_do,
    output logic       active,
    output logic [7:0] status,
    output logic       cmd_error
);
    localparam int MEM_BYTES = 1 << ADDR_BITS;
    localparam logic [ADDR_BITS-1:0] ADDR_ONE = ADDR_BITS'(1);

    typedef enum logic [2:0] {IDLE, CMD, ADDR, WDATA, RDATA, RDSR, WRSR, IGNORE} state_t;

    state_t               state, state_next;
    logic [1:0]           sclk_sync, cs_sync, di_sync;
    logic                 sclk_d, cs_d;
    logic                 sclk_rise, sclk_fall, cs_rise, cs_fall, di;
    logic [3:0]           bit_cnt;
    logic                 byte_done, first_done, is_write, cmd_error_next;
    logic [6:0]           rx_sr;
    logic [7:0]           rx_next, tx_sr, tx_load, mem_q;
    logic [ADDR_BITS-1:0] addr;
    logic                 page_mode, byte_mode;
    logic [7:0]           mem [MEM_BYTES];

    function automatic logic [7:0] status_fix(input logic [7:0] v);
        logic [1:0] m;
`ifdef MKMIF_SPI_SRAM_PAGE_MODE_EN
        m = v[7:6];
`else
        m = (v[7:6] == 2'b10) ? 2'b00 : v[7:6];
`endif
        return {m, 5'b0, v[0]};
    endfunction

    function automatic logic [ADDR_BITS-1:0] addr_inc(input logic [ADDR_BITS-1:0] a, input logic page);
        if (page)
            return {a[ADDR_BITS-1:5], a[4:0] + 5'd1};
        return a + ADDR_ONE;
    endfunction

    // Input synchronizers; edge flags come from the second stage vs. its delayed copy
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sclk_sync <= 2'b00;
            cs_sync   <= 2'b11;
            di_sync   <= 2'b00;
            sclk_d    <= 1'b0;
            cs_d      <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[0], spi_sclk};
            cs_sync   <= {cs_sync[0], spi_cs_n};
            di_sync   <= {di_sync[0], spi_di};
            sclk_d    <= sclk_sync[1];
            cs_d      <= cs_sync[1];
        end
    end

    // sclk edges only count while cs_n is low, so a coincident cs_n rise swallows them
    assign cs_rise   = cs_sync[1] & ~cs_d;
    assign cs_fall   = ~cs_sync[1] & cs_d;
    assign sclk_rise = sclk_sync[1] & ~sclk_d & ~cs_sync[1];
    assign sclk_fall = ~sclk_sync[1] & sclk_d & ~cs_sync[1];
    assign di        = di_sync[1];
    assign rx_next   = {rx_sr, di};
    assign byte_done = sclk_rise & (bit_cnt[2:0] == 3'd7);

`ifdef MKMIF_SPI_SRAM_PAGE_MODE_EN
    assign page_mode = (status[7:6] == 2'b10);
`else
    assign page_mode = 1'b0;
`endif
    assign byte_mode = (status[7:6] != 2'b01) && !page_mode;
    assign tx_load   = (state == RDSR) ? status : ((byte_mode && first_done) ? 8'h00 : mem_q);

    always_comb begin
        state_next     = state;
        cmd_error_next = 1'b0;
        if (cs_rise) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: if (cs_fall) state_next = CMD;
                CMD: begin
                    if (byte_done) begin
                        case (rx_next)
                            8'h02, 8'h03: state_next = ADDR;
                            8'h05:        state_next = RDSR;
                            8'h01:        state_next = WRSR;
                            default: begin
                                state_next     = IGNORE;
                                cmd_error_next = 1'b1;
                            end
                        endcase
                    end
                end
                ADDR: if (sclk_rise && bit_cnt == 4'd15) state_next = is_write ? WDATA : RDATA;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            bit_cnt    <= 4'd0;
            first_done <= 1'b0;
            is_write   <= 1'b0;
            status     <= 8'h00;
            cmd_error  <= 1'b0;
            active     <= 1'b0;
        end else begin
            state     <= state_next;
            cmd_error <= cmd_error_next;
            active    <= ~cs_sync[1];
            if (state_next != state) begin
                bit_cnt    <= 4'd0;
                first_done <= 1'b0;
            end else if (sclk_rise) begin
                bit_cnt <= bit_cnt + 4'd1;
                if (byte_done && (state == WDATA || state == RDATA || state == WRSR))
                    first_done <= 1'b1;
            end
            if (state == CMD && byte_done)
                is_write <= (rx_next == 8'h02);
            if (state == WRSR && byte_done && !first_done)
                status <= status_fix(rx_next);
        end
    end

    // Datapath: the address shifts straight into addr, keeping only the low ADDR_BITS bits
    always_ff @(posedge clk) begin
        mem_q <= mem[addr];
        if (sclk_rise)
            rx_sr <= rx_next[6:0];
        if (state == ADDR && sclk_rise)
            addr <= {addr[ADDR_BITS-2:0], di};
        if (byte_done && (state == WDATA || state == RDATA)) begin
            if (state == WDATA && !(byte_mode && first_done))
                mem[addr] <= rx_next;
            addr <= addr_inc(addr, page_mode);
        end
        if (sclk_fall && (state == RDATA || state == RDSR)) begin
            if (bit_cnt[2:0] == 3'd0)
                tx_sr <= {tx_load[6:0], 1'b0};
            else
                tx_sr <= {tx_sr[6:0], 1'b0};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            spi_do <= 1'b0;
        else if (state_next != RDATA && state_next != RDSR)
            spi_do <= 1'b0;
        else if (sclk_fall)
            spi_do <= (bit_cnt[2:0] == 3'd0) ? tx_load[7] : tx_sr[7];
    end

endmodule

// File: tb/tb_mkmif_spi_sram.sv
// Scoreboard bench for mkmif_spi_sram: a byte-level SRAM model predicts every spi_do byte; a monitor compares them.
`timescale 1ns/1ps
module tb_mkmif_spi_sram;
    logic       clk = 1'b0;
    logic       reset_n;
    logic       spi_sclk, spi_cs_n, spi_di;
    logic       spi_do, active, cmd_error;
    logic [7:0] status;

    mkmif_spi_sram #(.ADDR_BITS(13)) dut (
        .clk(clk), .reset_n(reset_n), .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n),
        .spi_di(spi_di), .spi_do(spi_do), .active(active), .status(status), .cmd_error(cmd_error)
    );

    always #5 clk = ~clk;

    typedef struct { logic [7:0] v; bit chk; } exp_t;
    exp_t       exp_q[$];
    logic [7:0] txb[$];
    int         checks = 0, errors = 0;
    logic [7:0] model_mem [8192];
    bit         model_known [8192];
    logic [7:0] model_status = 8'h00;
    int         exp_err_pulses = 0, err_pulses = 0, err_run = 0, max_err_run = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: assemble each full byte the master would sample and compare with the scoreboard
    logic [7:0] mon_sr;
    int         mon_cnt = 0;
    exp_t       mon_e;
    always @(posedge spi_sclk or posedge spi_cs_n) begin
        if (spi_cs_n) begin
            mon_cnt = 0;
        end else begin
            mon_sr = {mon_sr[6:0], spi_do};
            mon_cnt++;
            if (mon_cnt == 8) begin
                mon_cnt = 0;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spi_do_byte: got %h with nothing expected", mon_sr);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (mon_e.chk) begin
                        checks++;
                        if (mon_sr !== mon_e.v) begin
                            errors++;
                            $display("FAIL spi_do_byte: got %h expected %h", mon_sr, mon_e.v);
                        end
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cmd_error === 1'b1) begin
            err_run++;
            if (err_run == 1) err_pulses++;
            if (err_run > max_err_run) max_err_run = err_run;
        end else begin
            err_run = 0;
        end
    end

    function automatic logic [7:0] fix_status(input logic [7:0] v);
        logic [1:0] m;
        m = v[7:6];
`ifndef MKMIF_SPI_SRAM_PAGE_MODE_EN
        if (m == 2'b10) m = 2'b00;
`endif
        return {m, 5'b0, v[0]};
    endfunction

    function automatic int next_addr(input int a);
        bit page;
        page = 1'b0;
`ifdef MKMIF_SPI_SRAM_PAGE_MODE_EN
        page = (model_status[7:6] == 2'b10);
`endif
        if (page) return (a / 32) * 32 + ((a + 1) % 32);
        return (a + 1) % 8192;
    endfunction

    // Predict the response bytes of one select containing nfull complete bytes of txb
    task automatic model_xfer(input int nfull);
        logic [7:0] cmd;
        int         a;
        bit         bm;
        exp_t       e;
        if (nfull == 0) return;
        cmd = txb[0];
        a   = 0;
        if (txb.size() >= 3) a = ({txb[1], txb[2]}) % 8192;
        bm = (model_status[7:6] != 2'b01);
`ifdef MKMIF_SPI_SRAM_PAGE_MODE_EN
        if (model_status[7:6] == 2'b10) bm = 1'b0;
`endif
        if (cmd != 8'h01 && cmd != 8'h02 && cmd != 8'h03 && cmd != 8'h05) exp_err_pulses++;
        for (int i = 0; i < nfull; i++) begin
            e.v = 8'h00;
            e.chk = 1'b1;
            if (cmd == 8'h03 && i >= 3) begin
                if (!(i > 3 && bm)) begin
                    e.v = model_mem[a];
                    e.chk = model_known[a];
                end
                a = next_addr(a);
            end else if (cmd == 8'h02 && i >= 3) begin
                if (i == 3 || !bm) begin
                    model_mem[a] = txb[i];
                    model_known[a] = 1'b1;
                end
                a = next_addr(a);
            end else if (cmd == 8'h05 && i >= 1) begin
                e.v = model_status;
            end
            exp_q.push_back(e);
        end
        if (cmd == 8'h01 && nfull >= 2) model_status = fix_status(txb[1]);
    endtask

    task automatic half_period();
        repeat (5 + $urandom_range(0, 2)) @(posedge clk);
        #1;
    endtask

    task automatic spi_bit(input logic b);
        spi_di = b;
        half_period();
        spi_sclk = 1'b1;
        half_period();
        spi_sclk = 1'b0;
    endtask

    task automatic spi_xfer(input int nbits);
        logic [7:0] bb;
        model_xfer(nbits / 8);
        spi_cs_n = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("active_during_select", active, 1);
        for (int i = 0; i < nbits; i++) begin
            bb = txb[i / 8];
            spi_bit(bb[7 - (i % 8)]);
        end
        half_period();
        spi_cs_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("active_after_deselect", active, 0);
        chk("status_port", status, model_status);
    endtask

    initial begin
        #950_000;
        $display("FAIL watchdog: time limit reached, queue depth %0d expected 0", exp_q.size());
        $fatal(1, "watchdog");
    end

    initial begin
        int         pulses_before;
        logic [7:0] bb;
        exp_t       e;
        reset_n  = 1'b0;
        spi_cs_n = 1'b1;
        spi_sclk = 1'b0;
        spi_di   = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("reset_spi_do", spi_do, 0);
        chk("reset_active", active, 0);
        chk("reset_status", status, 8'h00);
        chk("reset_cmd_error", cmd_error, 0);
        reset_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;

        txb = '{8'h05, 8'h00};                                   spi_xfer(16);
        txb = '{8'h01, 8'h41};                                   spi_xfer(16);
        txb = '{8'h05, 8'h00, 8'h00};                            spi_xfer(24);
        txb = '{8'h02, 8'h00, 8'h10, 8'hDE, 8'hAD, 8'hBE, 8'hEF}; spi_xfer(56);
        txb = '{8'h03, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00}; spi_xfer(56);
        txb = '{8'h03, 8'hE0, 8'h10, 8'h00};                     spi_xfer(32);
        txb = '{8'h02, 8'h1F, 8'hFF, 8'hAA, 8'h55};              spi_xfer(40);
        txb = '{8'h03, 8'h1F, 8'hFF, 8'h00, 8'h00};              spi_xfer(40);
        txb = '{8'h03, 8'h00, 8'h00, 8'h00};                     spi_xfer(32);

        txb = '{8'h02, 8'h00, 8'h20, 8'h66, 8'h77, 8'h88, 8'h99}; spi_xfer(56);
        txb = '{8'h01, 8'h00};                                   spi_xfer(16);
        txb = '{8'h02, 8'h00, 8'h20, 8'h11, 8'h22};              spi_xfer(40);
        txb = '{8'h03, 8'h00, 8'h20, 8'h00, 8'h00};              spi_xfer(40);
        txb = '{8'h01, 8'h41};                                   spi_xfer(16);
        txb = '{8'h03, 8'h00, 8'h20, 8'h00, 8'h00};              spi_xfer(40);
        txb = '{8'h02, 8'h00, 8'h22, 8'h5A, 8'hFF};              spi_xfer(36);
        txb = '{8'h03, 8'h00, 8'h22, 8'h00, 8'h00};              spi_xfer(40);

        pulses_before = err_pulses;
        max_err_run = 0;
        txb = '{8'h9F, 8'hFF, 8'hFF, 8'hFF};                     spi_xfer(32);
        chk("cmd_error_pulse_count", err_pulses - pulses_before, 1);
        chk("cmd_error_pulse_width", max_err_run, 1);

        txb = '{8'h01, 8'h81};                                   spi_xfer(16);
        txb = '{8'h05, 8'h00};                                   spi_xfer(16);
`ifdef MKMIF_SPI_SRAM_PAGE_MODE_EN
        txb = '{8'h02, 8'h00, 8'h3E, 8'h01, 8'h02, 8'h03};       spi_xfer(48);
        txb = '{8'h03, 8'h00, 8'h3E, 8'h00, 8'h00, 8'h00};       spi_xfer(48);
        txb = '{8'h03, 8'h00, 8'h20, 8'h00};                     spi_xfer(32);
`endif

        // Reset in the middle of a WRITE select
        txb = '{8'h01, 8'h41};                                   spi_xfer(16);
        e.v = 8'h00;
        e.chk = 1'b1;
        exp_q.push_back(e);
        spi_cs_n = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        bb = 8'h02;
        for (int i = 0; i < 8; i++) spi_bit(bb[7 - i]);
        spi_bit(1'b1);
        spi_bit(1'b0);
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("midreset_status", status, 8'h00);
        chk("midreset_active", active, 0);
        chk("midreset_spi_do", spi_do, 0);
        spi_cs_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        model_status = 8'h00;
        repeat (4) @(posedge clk);
        #1;
        txb = '{8'h05, 8'h00};                                   spi_xfer(16);

        for (int n = 0; n < 30; n++) begin
            int         kind, len, nb;
            logic [15:0] a16;
            logic [7:0]  c;
            kind = $urandom_range(0, 4);
            a16 = ($urandom_range(0, 1) != 0) ? 16'($urandom_range(0, 63)) : 16'($urandom_range(8184, 8191));
            a16[15:13] = 3'($urandom_range(0, 7));
            len = $urandom_range(1, 5);
            case (kind)
                0:       c = 8'h03;
                1:       c = 8'h02;
                2:       c = 8'h05;
                3:       c = 8'h01;
                default: c = 8'h9F ^ 8'($urandom_range(0, 7));
            endcase
            txb.delete();
            txb.push_back(c);
            if (kind <= 1) begin
                txb.push_back(a16[15:8]);
                txb.push_back(a16[7:0]);
            end
            for (int k = 0; k < len; k++) txb.push_back(8'($urandom));
            nb = 8 * txb.size();
            if (txb.size() > 3 && $urandom_range(0, 5) == 0) nb = nb - $urandom_range(1, 7);
            spi_xfer(nb);
        end

        chk("scoreboard_drained", exp_q.size(), 0);
        chk("cmd_error_pulses_total", err_pulses, exp_err_pulses);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
